down_counter_timer: RTL and testbench

- Loadable, programmable down counter with a start/done handshake. It is the complement of the team's free-running up (ripple) counter.
- It counts a loaded value down to zero, then signals completion with a one-cycle done pulse.
- Optional auto-reload mode turns it into a periodic tick generator.
- Used as the timeout/interval source beside the existing counter blocks.

---
 rtl/down_counter_timer_if.sv | 23 ++
 rtl/down_counter_timer.sv | 87 ++++++++
 tb/tb_down_counter_timer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/down_counter_timer_if.sv
// rtl/down_counter_timer_if.sv - control and status bundle for the down counter timer
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, stop, auto_reload,
    input  out, busy, done
  );

  modport slave (
    input  load, load_val, start, stop, auto_reload,
    output out, busy, done
  );
endinterface

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down counter with start/done handshake and auto-reload
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  down_counter_timer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q  <= IDLE;
      out_q    <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= (state_d == RUN);
    end
  end

  // Priority within a state: stop > load > start/count.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.stop) begin
          if (bus.load) begin
            out_d    = bus.load_val;
            reload_d = bus.load_val;
          end else if (bus.start) begin
            if (out_q != '0) begin
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.load) begin
          out_d    = bus.load_val;
          reload_d = bus.load_val;
          done_d   = (bus.load_val == '0);
        end else if (out_q == '0) begin
          // Zero was reached last edge: reload for periodic mode, otherwise retire.
          if (bus.auto_reload && (reload_q != '0)) begin
            out_d = reload_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          out_d  = out_q - WIDTH'(1);
          done_d = (out_q == WIDTH'(1));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - directed and randomized self-checking bench for down_counter_timer
module tb_down_counter_timer;

  localparam int WIDTH = 4;

  logic clock = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  down_counter_timer_if #(.WIDTH(WIDTH)) bus ();

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Behavioural reference: the timer's observable state as plain integers.
  int m_out;
  int m_reload;
  bit m_run;
  bit m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit c, input bit ld, input int lv, input bit st,
                            input bit sp, input bit ar);
    m_done = 1'b0;
    if (!c) begin
      m_out = 0; m_reload = 0; m_run = 1'b0;
    end else if (sp) begin
      m_run = 1'b0;
    end else if (ld) begin
      m_out = lv; m_reload = lv;
      if (m_run && lv == 0) m_done = 1'b1;
    end else if (!m_run) begin
      if (st) begin
        if (m_out != 0) m_run = 1'b1;
        else m_done = 1'b1;
      end
    end else if (m_out == 0) begin
      if (ar && m_reload != 0) m_out = m_reload;
      else m_run = 1'b0;
    end else begin
      m_out = m_out - 1;
      if (m_out == 0) m_done = 1'b1;
    end
  endtask

  task automatic step(input bit c, input bit ld, input int lv, input bit st,
                      input bit sp, input bit ar);
    clear           = c;
    bus.load        = ld;
    bus.load_val    = lv[WIDTH-1:0];
    bus.start       = st;
    bus.stop        = sp;
    bus.auto_reload = ar;
    @(posedge clock);
    model_edge(c, ld, lv, st, sp, ar);
    #1;
    chk("out",  32'(bus.out),  32'(m_out));
    chk("busy", 32'(bus.busy), 32'(m_run));
    chk("done", 32'(bus.done), 32'(m_done));
  endtask

  task automatic idle(input bit ar);
    step(1, 0, 0, 0, 0, ar);
  endtask

  int done_at[$];
  int n;

  initial begin
    m_out = 0; m_reload = 0; m_run = 0; m_done = 0;
    clear = 1'b0;
    bus.load = 0; bus.load_val = '0; bus.start = 0; bus.stop = 0; bus.auto_reload = 0;
    #1;

    // Power-up reset
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("reset_out", 32'(bus.out), 0);
    chk("reset_busy", 32'(bus.busy), 0);

    // Reset mid-count at out=9
    step(1, 1, 9, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("run9_out", 32'(bus.out), 9);
    step(0, 0, 0, 0, 0, 0);
    chk("clr_out", 32'(bus.out), 0);
    chk("clr_busy", 32'(bus.busy), 0);
    chk("clr_done", 32'(bus.done), 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (3) idle(0);
    chk("clr_stays_idle", 32'(bus.busy), 0);

    // Basic count 5..0
    step(1, 1, 5, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("basic_start_out", 32'(bus.out), 5);
    chk("basic_start_busy", 32'(bus.busy), 1);
    for (int i = 4; i >= 0; i--) begin
      idle(0);
      chk("basic_seq", 32'(bus.out), 32'(i));
      chk("basic_done", 32'(bus.done), (i == 0) ? 32'd1 : 32'd0);
    end
    idle(0);
    chk("basic_busy_fall", 32'(bus.busy), 0);
    chk("basic_hold0", 32'(bus.out), 0);

    // Auto-reload with period N+1
    step(1, 1, 3, 0, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    done_at.delete();
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (bus.done) done_at.push_back(i);
    end
    chk("ar_pulse_count", 32'(done_at.size()), 3);
    for (int i = 1; i < done_at.size(); i++)
      chk("ar_period", 32'(done_at[i] - done_at[i-1]), 4);
    n = 0;
    while (bus.busy && n < 10) begin
      idle(0);
      n++;
    end
    chk("ar_off_to_idle", 32'(bus.busy), 0);
    chk("ar_off_out", 32'(bus.out), 0);

    // Stop at out=4, then stop+load priority
    step(1, 1, 8, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    repeat (4) idle(0);
    step(1, 0, 0, 0, 1, 0);
    chk("stop_out", 32'(bus.out), 4);
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_done", 32'(bus.done), 0);
    step(1, 1, 7, 0, 1, 0);
    chk("stop_over_load", 32'(bus.out), 4);

    // Zero-length timeout
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("zero_start_done", 32'(bus.done), 1);
    chk("zero_start_busy", 32'(bus.busy), 0);
    idle(0);
    chk("zero_done_once", 32'(bus.done), 0);

    // Restart load 2 while running at 6
    step(1, 1, 9, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    repeat (3) idle(0);
    chk("pre_reload_out", 32'(bus.out), 6);
    step(1, 1, 2, 0, 0, 0);
    chk("reload2_out", 32'(bus.out), 2);
    chk("reload2_nodone", 32'(bus.done), 0);
    idle(0);
    idle(0);
    chk("reload2_zero_done", 32'(bus.done), 1);
    idle(0);

    // Load 0 while running
    step(1, 1, 4, 0, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    idle(1);
    step(1, 1, 0, 0, 0, 1);
    chk("load0_done", 32'(bus.done), 1);
    idle(1);
    chk("load0_idle", 32'(bus.busy), 0);

    // Full range 15 with no underflow
    step(1, 1, 15, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    n = 1;
    while (!bus.done && n < 40) begin
      idle(0);
      n++;
    end
    chk("full_cycles", 32'(n), 16);
    repeat (4) idle(0);
    chk("no_underflow", 32'(bus.out), 0);

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
